packet_rx: RTL and testbench

Receive-side framer for the application-layer link. It takes the byte stream recovered by the physical layer and hunts for a header byte. It then assembles four payload bytes MSB-first into a 32-bit word and checks the trailing CRC-8 byte. The polynomial is 0xD5 (DVB-S2), with init 0x00 and no final XOR, matching the transmit-side crc8. Validated words go to the application; bad or stalled frames are flagged and dropped.

---
 rtl/packet_rx.sv | 169 ++++++++++++++++
 tb/tb_packet_rx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/packet_rx.sv
// packet_rx: receive-side framer. Hunts for the HEADER byte, assembles four
// payload bytes MSB-first into a 32-bit word, then checks a trailing CRC-8
// (poly 0xD5, init 0x00, no final XOR). Good words are published on data
// with a data_valid pulse; CRC mismatches pulse crc_err; an inter-byte gap
// of TIMEOUT cycles inside a frame pulses frame_abort.
//
// Optional feature: define PKT_RX_STATS_EN to add saturating good_cnt /
// bad_cnt statistics ports (STAT_W bits wide).
//
// Handshake: byte_valid is a one-cycle strobe with no back-pressure; every
// cycle with byte_valid high delivers exactly one byte on byte_in. All
// outputs except busy are registered one-cycle pulses or held values.
module packet_rx #(
    parameter logic [7:0] HEADER  = 8'hA5,
    parameter int         TIMEOUT = 1024,
    parameter int         STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic [31:0]       data,
    output logic              data_valid,
    output logic              crc_err,
    output logic              frame_abort,
`ifdef PKT_RX_STATS_EN
    output logic [STAT_W-1:0] good_cnt,
    output logic [STAT_W-1:0] bad_cnt,
`endif
    output logic              busy
);

    localparam logic [1:0] ST_HUNT    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_CHECK   = 2'd2;

    localparam int                IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    // One table step T[crc ^ b], computed as the equivalent 8-step serial shift.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] c;
        c = crc ^ b;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'hD5) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    logic [1:0]        state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [7:0]        crc_q, crc_d;
    logic [31:0]       asm_q, asm_d;
    logic [31:0]       data_q, data_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              dv_q, dv_d;
    logic              ce_q, ce_d;
    logic              ab_q, ab_d;

    // Next-state logic: frame sequencing, CRC accumulation and gap timeout.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        crc_d   = crc_q;
        asm_d   = asm_q;
        data_d  = data_q;
        idle_d  = idle_q;
        dv_d    = 1'b0;
        ce_d    = 1'b0;
        ab_d    = 1'b0;
        case (state_q)
            ST_HUNT: begin
                // Counter held at zero here, so entry to PAYLOAD starts clean.
                idle_d = '0;
                if (byte_valid && byte_in == HEADER) begin
                    state_d = ST_PAYLOAD;
                    idx_d   = 2'd0;
                    crc_d   = 8'h00;
                end
            end
            ST_PAYLOAD, ST_CHECK: begin
                // A byte arriving on the would-be timeout cycle is accepted.
                if (byte_valid) begin
                    idle_d = '0;
                    if (state_q == ST_PAYLOAD) begin
                        asm_d = {asm_q[23:0], byte_in};
                        crc_d = crc8_step(crc_q, byte_in);
                        idx_d = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_d = ST_CHECK;
                        end
                    end else begin
                        if (byte_in == crc_q) begin
                            data_d = asm_q;
                            dv_d   = 1'b1;
                        end else begin
                            ce_d = 1'b1;
                        end
                        state_d = ST_HUNT;
                    end
                end else if (idle_q == IDLE_LAST) begin
                    state_d = ST_HUNT;
                    ab_d    = 1'b1;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_HUNT;
            idx_q   <= 2'd0;
            crc_q   <= 8'h00;
            asm_q   <= 32'h0;
            data_q  <= 32'h0;
            idle_q  <= '0;
            dv_q    <= 1'b0;
            ce_q    <= 1'b0;
            ab_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            crc_q   <= crc_d;
            asm_q   <= asm_d;
            data_q  <= data_d;
            idle_q  <= idle_d;
            dv_q    <= dv_d;
            ce_q    <= ce_d;
            ab_q    <= ab_d;
        end
    end

    assign data        = data_q;
    assign data_valid  = dv_q;
    assign crc_err     = ce_q;
    assign frame_abort = ab_q;
    assign busy        = (state_q != ST_HUNT);

`ifdef PKT_RX_STATS_EN
    logic [STAT_W-1:0] good_q;
    logic [STAT_W-1:0] bad_q;

    // Saturating statistics, updated on the same edge that raises each pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            good_q <= '0;
            bad_q  <= '0;
        end else begin
            if (dv_d && good_q != {STAT_W{1'b1}}) begin
                good_q <= good_q + 1'b1;
            end
            if ((ce_d || ab_d) && bad_q != {STAT_W{1'b1}}) begin
                bad_q <= bad_q + 1'b1;
            end
        end
    end

    assign good_cnt = good_q;
    assign bad_cnt  = bad_q;
`endif

endmodule

// File: tb/tb_packet_rx.sv
// tb_packet_rx: directed test of packet_rx with TIMEOUT=8 and STAT_W=2.
// Expected CRC bytes were worked out by hand for poly 0xD5:
//   00,00,00,01 -> D5   00,00,00,02 -> 7F   A5,00,00,00 -> 56
module tb_packet_rx;

  logic        clk;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic [31:0] data;
  logic        data_valid;
  logic        crc_err;
  logic        frame_abort;
  logic        busy;
`ifdef PKT_RX_STATS_EN
  logic [1:0]  good_cnt;
  logic [1:0]  bad_cnt;
`endif

  int errors = 0;
  int checks = 0;

  packet_rx #(
    .HEADER  (8'hA5),
    .TIMEOUT (8),
    .STAT_W  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .data        (data),
    .data_valid  (data_valid),
    .crc_err     (crc_err),
    .frame_abort (frame_abort),
`ifdef PKT_RX_STATS_EN
    .good_cnt    (good_cnt),
    .bad_cnt     (bad_cnt),
`endif
    .busy        (busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: one clock cycle; inputs set at negedge, outputs observed #1 after posedge.
  task automatic step(input logic v, input logic [7:0] b);
    @(negedge clk);
    byte_valid = v;
    byte_in    = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst        = 1'b1;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected %h", data, 32'h0); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b expected 0", data_valid); end
    checks++; if (crc_err !== 1'b0) begin errors++; $display("FAIL reset_crc_err: got %b expected 0", crc_err); end
    checks++; if (frame_abort !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b expected 0", frame_abort); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
`ifdef PKT_RX_STATS_EN
    checks++; if (good_cnt !== 2'd0 || bad_cnt !== 2'd0) begin errors++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", good_cnt, bad_cnt); end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_good_frame;
    step(1'b1, 8'hA5);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL good_busy_rise: got %b expected 1", busy); end
    step(1'b1, 8'h00);
    step(1'b1, 8'h00);
    step(1'b1, 8'h00);
    step(1'b1, 8'h01);
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL good_dv_early: got %b expected 0", data_valid); end
    step(1'b1, 8'hD5);
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL good_dv: got %b expected 1", data_valid); end
    checks++; if (data !== 32'h00000001) begin errors++; $display("FAIL good_data: got %h expected %h", data, 32'h00000001); end
    checks++; if (crc_err !== 1'b0) begin errors++; $display("FAIL good_no_crc_err: got %b expected 0", crc_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_busy_fall: got %b expected 0", busy); end
`ifdef PKT_RX_STATS_EN
    checks++; if (good_cnt !== 2'd1) begin errors++; $display("FAIL good_cnt1: got %0d expected 1", good_cnt); end
`endif
    step(1'b0, 8'h00);
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL good_dv_width: got %b expected 0", data_valid); end
  endtask

  task automatic test_bad_crc;
    step(1'b1, 8'hA5);
    step(1'b1, 8'h00);
    step(1'b1, 8'h00);
    step(1'b1, 8'h00);
    step(1'b1, 8'h02);
    step(1'b1, 8'h00);
    checks++; if (crc_err !== 1'b1) begin errors++; $display("FAIL bad_crc_err: got %b expected 1", crc_err); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL bad_no_dv: got %b expected 0", data_valid); end
    checks++; if (data !== 32'h00000001) begin errors++; $display("FAIL bad_data_held: got %h expected %h", data, 32'h00000001); end
`ifdef PKT_RX_STATS_EN
    checks++; if (bad_cnt !== 2'd1) begin errors++; $display("FAIL bad_cnt1: got %0d expected 1", bad_cnt); end
`endif
    step(1'b0, 8'h00);
    checks++; if (crc_err !== 1'b0) begin errors++; $display("FAIL bad_crc_err_width: got %b expected 0", crc_err); end
  endtask

  task automatic test_hunt_filter;
    logic [7:0] f1 [8] = '{8'h11, 8'h22, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h02, 8'h7F};
    logic [7:0] f2 [6] = '{8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h56};
    step(1'b1, f1[0]);
    step(1'b1, f1[1]);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hunt_ignore: got busy %b expected 0", busy); end
    for (int i = 2; i < 8; i++) step(1'b1, f1[i]);
    checks++; if (data_valid !== 1'b1 || data !== 32'h00000002) begin errors++; $display("FAIL hunt_data: got dv %b data %h expected dv 1 data %h", data_valid, data, 32'h00000002); end
    // Next header immediately after the CRC byte; A5 in payload is data.
    for (int i = 0; i < 6; i++) step(1'b1, f2[i]);
    checks++; if (data_valid !== 1'b1 || data !== 32'hA5000000) begin errors++; $display("FAIL hunt_hdr_payload: got dv %b data %h expected dv 1 data %h", data_valid, data, 32'hA5000000); end
`ifdef PKT_RX_STATS_EN
    checks++; if (good_cnt !== 2'd3) begin errors++; $display("FAIL hunt_good_cnt: got %0d expected 3", good_cnt); end
`endif
    step(1'b0, 8'h00);
  endtask

  task automatic test_timeout;
    step(1'b1, 8'hA5);
    step(1'b1, 8'h12);
    step(1'b1, 8'h34);
    for (int i = 1; i <= 7; i++) begin
      step(1'b0, 8'h00);
      if (frame_abort !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL timeout_early idle %0d: got abort %b busy %b expected abort 0 busy 1", i, frame_abort, busy);
      end
      checks++;
    end
    step(1'b0, 8'h00);
    checks++; if (frame_abort !== 1'b1) begin errors++; $display("FAIL timeout_abort: got %b expected 1", frame_abort); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b expected 0", busy); end
    checks++; if (data !== 32'hA5000000) begin errors++; $display("FAIL timeout_data_held: got %h expected %h", data, 32'hA5000000); end
`ifdef PKT_RX_STATS_EN
    checks++; if (bad_cnt !== 2'd2) begin errors++; $display("FAIL timeout_bad_cnt: got %0d expected 2", bad_cnt); end
`endif
    step(1'b0, 8'h00);
    checks++; if (frame_abort !== 1'b0) begin errors++; $display("FAIL timeout_abort_width: got %b expected 0", frame_abort); end
  endtask

  task automatic test_timeout_collision;
    step(1'b1, 8'hA5);
    step(1'b1, 8'h00);
    step(1'b1, 8'h00);
    repeat (7) step(1'b0, 8'h00);
    // Byte lands on the cycle the counter would reach TIMEOUT.
    step(1'b1, 8'h00);
    checks++; if (frame_abort !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL collision_no_abort: got abort %b busy %b expected abort 0 busy 1", frame_abort, busy); end
    step(1'b1, 8'h01);
    step(1'b1, 8'hD5);
    checks++; if (data_valid !== 1'b1 || data !== 32'h00000001) begin errors++; $display("FAIL collision_data: got dv %b data %h expected dv 1 data %h", data_valid, data, 32'h00000001); end
`ifdef PKT_RX_STATS_EN
    checks++; if (good_cnt !== 2'd3) begin errors++; $display("FAIL collision_good_sat: got %0d expected 3", good_cnt); end
`endif
    step(1'b0, 8'h00);
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] f [6] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'hD5};
    step(1'b1, 8'hA5);
    step(1'b1, 8'h12);
    @(negedge clk);
    byte_valid = 1'b0;
    rst        = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || data !== 32'h0) begin errors++; $display("FAIL rstmid_outputs: got busy %b data %h expected busy 0 data 0", busy, data); end
    checks++; if (data_valid !== 1'b0 || crc_err !== 1'b0 || frame_abort !== 1'b0) begin errors++; $display("FAIL rstmid_pulses: got %b%b%b expected 000", data_valid, crc_err, frame_abort); end
`ifdef PKT_RX_STATS_EN
    checks++; if (good_cnt !== 2'd0 || bad_cnt !== 2'd0) begin errors++; $display("FAIL rstmid_stats: got %0d/%0d expected 0/0", good_cnt, bad_cnt); end
`endif
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b1, f[i]);
    checks++; if (data_valid !== 1'b1 || data !== 32'h00000001) begin errors++; $display("FAIL rstmid_frame: got dv %b data %h expected dv 1 data %h", data_valid, data, 32'h00000001); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] f [12] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h02, 8'h7F,
                           8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h56};
    for (int i = 0; i < 6; i++) step(1'b1, f[i]);
    checks++; if (data_valid !== 1'b1 || data !== 32'h00000002) begin errors++; $display("FAIL b2b_first: got dv %b data %h expected dv 1 data %h", data_valid, data, 32'h00000002); end
    for (int i = 6; i < 12; i++) step(1'b1, f[i]);
    checks++; if (data_valid !== 1'b1 || data !== 32'hA5000000) begin errors++; $display("FAIL b2b_second: got dv %b data %h expected dv 1 data %h", data_valid, data, 32'hA5000000); end
`ifdef PKT_RX_STATS_EN
    checks++; if (good_cnt !== 2'd3 || bad_cnt !== 2'd0) begin errors++; $display("FAIL b2b_stats_sat: got %0d/%0d expected 3/0", good_cnt, bad_cnt); end
`endif
    step(1'b0, 8'h00);
    checks++; if (data_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got dv %b busy %b expected 0 0", data_valid, busy); end
  endtask

  initial begin
    test_reset;
    test_good_frame;
    test_bad_crc;
    test_hunt_filter;
    test_timeout;
    test_timeout_collision;
    test_reset_mid_frame;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
